fcmp_pipe: RTL
==============

Name: fcmp_pipe

Overview:
- Two-stage pipelined floating-point predicate unit for IEEE-754 single-precision operands.
- Evaluates the sign/zero tests (the same tests as the standalone fisneg/fiszero combinational units) and the two-operand compares feq/flt/fle.
- Sits between FPU issue and the integer branch/writeback path; the 1-bit result is returned with an issue tag.
- Uses a valid/ready handshake on both sides so the consumer can stall it.

Parameters:
- TAG_W, 5, width of the opaque tag carried alongside each operation (destination register index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  block accepts the operation this cycle.
- in_op  in  3  predicate select: 000 FISNEG, 001 FISZERO, 010 FISPOS, 011 FEQ, 100 FLT, 101 FLE, 110/111 reserved.
- in_x1  in  32  first operand (sole operand for unary ops).
- in_x2  in  32  second operand; ignored for unary ops.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes the result this cycle.
- out_result  out  1  predicate result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: on clk with rst=1, s1_valid=0 and s2_valid=0.
  - After reset: out_valid=0, out_result=0, out_tag=0, in_ready=1.
  - Reset mid-operation discards all in-flight ops.
- Handshake:
  - Transfer occurs on any cycle where valid&&ready.
  - out_valid, out_result and out_tag are held stable while out_valid=1 and out_ready=0.
- Stage 1 (classify): registers the op, tag, and per-operand fields.
  - Fields captured: sign; zero = (exp==0), so denormals are flushed to zero; mag = bits[30:0].
  - Also registers the magnitude-compare result mag1<mag2 and the equality flag mag1==mag2.
- Stage 2 (decide): registers the result and tag.
- Stall logic:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1/cycle when out_ready stays high.
- Predicates (z = zero flag, s = sign):
  - FISNEG = s1 && !z1, so -0 is false.
  - FISZERO = z1.
  - FISPOS = !s1 && !z1.
  - FEQ = (z1&&z2) || (x1==x2 bitwise). Zeros of any sign or denormal payload compare equal.
  - FLT:
    - both zero: false.
    - signs differ: true iff x1 is negative and not both zero; a zero counts as +0.
    - both positive: mag1<mag2.
    - both negative: mag2<mag1.
    - Zero operands are treated with mag=0, s=0.
  - FLE = FLT || FEQ.
  - Reserved ops: result 0; the op still completes and its tag is returned.
- Simultaneous accept and drain in the same cycle is legal; the pipeline shifts with no bubble.
- NaN/Inf: no special treatment unless FCMP_NAN_EN is defined. Inf orders correctly by magnitude.

Optional Feature:
- Macro: FCMP_NAN_EN.
- When defined:
  - Stage 1 also registers nan = (exp==8'hFF && frac!=0) for each operand.
  - FEQ, FLT and FLE return 0 if either operand is NaN.
  - FISNEG and FISPOS return 0 for a NaN operand.
  - FISZERO is unchanged.
- When undefined: NaN operands are compared as ordinary bit patterns per the rules above, and no nan flops exist.

Decomposition:
- Package fcmp_pkg holds:
  - typedef enum logic [2:0] fcmp_op_t (FISNEG..FLE).
  - constants EXP_ZERO=8'h00 and EXP_MAX=8'hFF.
  - typedef struct fcls_t {sign, zero, nan, mag[30:0]}.
- One sub-module, fcmp_classify: combinational, 32-bit operand in, fcls_t out. It is instantiated twice in stage 1.

Test Plan:
- After reset with in_valid=0 → out_valid=0 and out_result=0. Then FISNEG x1=32'hBF800000 (-1.0), tag 3 → after 2 cycles out_valid=1, out_result=1, out_tag=3.
- FISNEG with 32'h80000000 (-0) and with 32'h80000001 (negative denormal) → result 0. FISZERO with the same operands → result 1.
- FLT x1=32'hC0000000 (-2), x2=32'hBF800000 (-1) → 1. Swapped → 0. FLE with 32'h00000000 and 32'h80000000 → 1. FEQ with the same pair → 1.
- Back-to-back stream of 8 ops with out_ready=1 → 8 results on consecutive cycles in order, tags 0..7. Then hold out_ready=0 for 5 cycles → in_ready drops after 2 more accepts, outputs are held stable, and no result is lost on release.
- Assert rst for 1 cycle while both stages are valid → out_valid=0 the next cycle and no stale tag appears afterwards.
- With FCMP_NAN_EN: FEQ x1=x2=32'h7FC00000 → 0, and FLT 32'h7FC00000 vs 32'h3F800000 → 0. Without the macro, FEQ on the same pair → 1.

Source files
------------

// File: rtl/fcmp_pkg.sv
// Shared types and constants for the pipelined single-precision predicate unit.
package fcmp_pkg;

    typedef enum logic [2:0] {
        FISNEG  = 3'b000,
        FISZERO = 3'b001,
        FISPOS  = 3'b010,
        FEQ     = 3'b011,
        FLT     = 3'b100,
        FLE     = 3'b101
    } fcmp_op_t;

    localparam logic [7:0] EXP_ZERO = 8'h00;
    localparam logic [7:0] EXP_MAX  = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        nan;
        logic [30:0] mag;
    } fcls_t;

endpackage

// File: rtl/fcmp_classify.sv
// Combinational operand classifier: sign, flush-to-zero flag, NaN flag and magnitude.
module fcmp_classify
    import fcmp_pkg::*;
(
    input  logic [31:0] x,
    output fcls_t       cls
);

    always_comb begin
        cls.sign = x[31];
        cls.zero = (x[30:23] == EXP_ZERO);
        cls.nan  = (x[30:23] == EXP_MAX) && (x[22:0] != '0);
        cls.mag  = x[30:0];
    end

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage valid/ready predicate pipeline (FISNEG/FISZERO/FISPOS/FEQ/FLT/FLE).
// Optional NaN-aware compares are enabled by defining FCMP_NAN_EN.
module fcmp_pipe
    import fcmp_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [TAG_W-1:0] out_tag
);

    fcls_t c1, c2;

    fcmp_classify u_cls1 (.x(in_x1), .cls(c1));
    fcmp_classify u_cls2 (.x(in_x2), .cls(c2));

    logic             s1_valid, s2_valid;
    logic             s2_adv, s1_adv;
    logic [2:0]       s1_op;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic             s1_sign1, s1_sign2, s1_zero1, s1_zero2;
    logic             s1_lt, s1_eq;
    logic             s2_result;
    logic             result;
`ifdef FCMP_NAN_EN
    logic             s1_nan1, s1_nan2;
`else
    logic             unused_nan;
    assign unused_nan = c1.nan ^ c2.nan;
`endif

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_result <= 1'b0;
            s2_tag    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op    <= in_op;
                    s1_tag   <= in_tag;
                    s1_sign1 <= c1.sign;
                    s1_sign2 <= c2.sign;
                    s1_zero1 <= c1.zero;
                    s1_zero2 <= c2.zero;
                    s1_lt    <= (c1.mag < c2.mag);
                    s1_eq    <= (c1.mag == c2.mag);
`ifdef FCMP_NAN_EN
                    s1_nan1  <= c1.nan;
                    s1_nan2  <= c2.nan;
`endif
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= result;
                    s2_tag    <= s1_tag;
                end
            end
        end
    end

    // Zeros act as +0 in ordering; raw magnitudes still order correctly since a
    // flushed denormal is always below any normal magnitude.
    always_comb begin
        logic es1, es2, both_zero, feq, flt, nan1, nan_any;
        es1       = s1_sign1 & ~s1_zero1;
        es2       = s1_sign2 & ~s1_zero2;
        both_zero = s1_zero1 & s1_zero2;
        feq       = both_zero | ((s1_sign1 == s1_sign2) & s1_eq);
        if (both_zero)       flt = 1'b0;
        else if (es1 != es2) flt = es1;
        else if (!es1)       flt = s1_lt;
        else                 flt = ~s1_lt & ~s1_eq;
`ifdef FCMP_NAN_EN
        nan1    = s1_nan1;
        nan_any = s1_nan1 | s1_nan2;
`else
        nan1    = 1'b0;
        nan_any = 1'b0;
`endif
        case (s1_op)
            FISNEG:  result = es1 & ~nan1;
            FISZERO: result = s1_zero1;
            FISPOS:  result = ~s1_sign1 & ~s1_zero1 & ~nan1;
            FEQ:     result = feq & ~nan_any;
            FLT:     result = flt & ~nan_any;
            FLE:     result = (flt | feq) & ~nan_any;
            default: result = 1'b0;
        endcase
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;

endmodule
